// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port ROM arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  // Only a plain synchronous ROM (1) or one with an output register (2) exists.
  function automatic bit latency_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Request/response bundle for both ROM requesters.
// Handshake: a request transfers on a rising edge where reqN_valid && reqN_ready;
// reqN_addr is sampled only then, valid may drop at any time before that, and
// rspN_valid is a single-cycle pulse with no backpressure.
interface rom_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic                  req0_ready;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_data;

  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic                  req1_ready;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_data;

  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/rom_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that was not granted last.
module rom_arb_rr (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] sel
);
  assign sel[0] = valid[0] & (~valid[1] | last_grant);
  assign sel[1] = valid[1] & (~valid[0] | ~last_grant);
endmodule

// File: rtl/rom_arbiter.sv
// Shares one synchronous-read ROM between the Z80 port (0) and the loader
// port (1), one read at a time, covering the ROM's fixed read latency.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  rom_arbiter_if.slave          bus,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  busy,
  output state_t                fsm_state
);

  generate
    if (!latency_ok(ROM_LATENCY)) begin : g_bad_latency
      $fatal(1, "rom_arbiter: ROM_LATENCY must be 1 or 2");
    end
  endgenerate

  state_t     state;
  logic       gnt;
  logic       last_grant;
  logic [1:0] cnt;
  logic [1:0] sel;
  logic       idle;

  rom_arb_rr u_rr (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant),
    .sel        (sel)
  );

  assign idle           = (state == IDLE);
  assign bus.req0_ready = idle & sel[0];
  assign bus.req1_ready = idle & sel[1];
  assign busy           = ~idle;
  assign fsm_state      = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rom_address    <= '0;
      gnt            <= PORT_CPU;
      last_grant     <= PORT_LDR;
      cnt            <= 2'd0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp0_data  <= '0;
      bus.rsp1_data  <= '0;
    end else begin
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0_valid && bus.req0_ready) begin
            rom_address <= bus.req0_addr;
            gnt         <= PORT_CPU;
            last_grant  <= PORT_CPU;
            cnt         <= 2'(ROM_LATENCY);
            state       <= WAIT;
          end else if (bus.req1_valid && bus.req1_ready) begin
            rom_address <= bus.req1_addr;
            gnt         <= PORT_LDR;
            last_grant  <= PORT_LDR;
            cnt         <= 2'(ROM_LATENCY);
            state       <= WAIT;
          end
        end
        WAIT: begin
          // rom_address is held here so the ROM output settles undisturbed.
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) state <= CAPTURE;
        end
        CAPTURE: begin
          if (gnt == PORT_CPU) begin
            bus.rsp0_data  <= rom_data;
            bus.rsp0_valid <= 1'b1;
          end else begin
            bus.rsp1_data  <= rom_data;
            bus.rsp1_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: one instance per ROM latency, each with its own ROM model.
module tb_rom_arbiter;
  import rom_arb_pkg::*;

  localparam int DW = 8;
  localparam int AW = 12;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  rom_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  rom_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

  logic [AW-1:0] rom_address_a, rom_address_b;
  logic [DW-1:0] rom_data_a = '0, rom_data_b = '0, rom_stage_b = '0;
  logic          busy_a, busy_b;
  state_t        fsm_state_a, fsm_state_b;

  function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // ROM models: plain synchronous read, and the same with an output register.
  always @(posedge clock) rom_data_a <= rom_val(rom_address_a);
  always @(posedge clock) begin
    rom_stage_b <= rom_val(rom_address_b);
    rom_data_b  <= rom_stage_b;
  end

  rom_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROM_LATENCY(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a),
    .rom_address(rom_address_a), .rom_data(rom_data_a),
    .busy(busy_a), .fsm_state(fsm_state_a)
  );

  rom_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROM_LATENCY(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b),
    .rom_address(rom_address_b), .rom_data(rom_data_b),
    .busy(busy_b), .fsm_state(fsm_state_b)
  );

  // ---------------- driver tasks ----------------
  // Apply inputs after the falling edge, then settle; outputs are read after return.
  task automatic drive_a(input logic v0, input logic [AW-1:0] a0,
                         input logic v1, input logic [AW-1:0] a1);
    @(negedge clock);
    bus_a.req0_valid = v0; bus_a.req0_addr = a0;
    bus_a.req1_valid = v1; bus_a.req1_addr = a1;
    #1;
  endtask

  task automatic drive_b(input logic v0, input logic [AW-1:0] a0,
                         input logic v1, input logic [AW-1:0] a1);
    @(negedge clock);
    bus_b.req0_valid = v0; bus_b.req0_addr = a0;
    bus_b.req1_valid = v1; bus_b.req1_addr = a1;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    bus_a.req0_valid = 1'b0; bus_a.req1_valid = 1'b0;
    bus_b.req0_valid = 1'b0; bus_b.req1_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_cmp++; if (fsm_state_a !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want IDLE", fsm_state_a); end
    n_cmp++; if (rom_address_a !== '0) begin n_bad++; $display("FAIL reset_addr: got %h want 000", rom_address_a); end
    n_cmp++; if ({bus_a.rsp0_valid, bus_a.rsp1_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 00", {bus_a.rsp0_valid, bus_a.rsp1_valid}); end
    n_cmp++; if ({bus_a.rsp0_data, bus_a.rsp1_data} !== 16'h0) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0000", {bus_a.rsp0_data, bus_a.rsp1_data}); end
    n_cmp++; if ({bus_a.req0_ready, bus_a.req1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", {bus_a.req0_ready, bus_a.req1_ready}); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_single_port0();
    drive_a(1'b1, 12'h010, 1'b0, '0);
    n_cmp++; if ({bus_a.req0_ready, bus_a.req1_ready} !== 2'b10) begin n_bad++; $display("FAIL single_ready: got %b want 10", {bus_a.req0_ready, bus_a.req1_ready}); end
    for (int c = 1; c <= 4; c++) begin
      drive_a(1'b0, '0, 1'b0, '0);
      n_cmp++; if (bus_a.rsp0_valid !== (c == 3)) begin n_bad++; $display("FAIL single_rsp0_valid c%0d: got %b want %b", c, bus_a.rsp0_valid, c == 3); end
      n_cmp++; if (bus_a.rsp1_valid !== 1'b0) begin n_bad++; $display("FAIL single_rsp1_valid c%0d: got %b want 0", c, bus_a.rsp1_valid); end
      n_cmp++; if (busy_a !== (c < 3)) begin n_bad++; $display("FAIL single_busy c%0d: got %b want %b", c, busy_a, c < 3); end
      if (c >= 3) begin
        n_cmp++; if (bus_a.rsp0_data !== 8'hB5) begin n_bad++; $display("FAIL single_data c%0d: got %h want b5", c, bus_a.rsp0_data); end
      end
    end
    n_cmp++; if (rom_address_a !== 12'h010) begin n_bad++; $display("FAIL single_rom_addr: got %h want 010", rom_address_a); end
  endtask

  task automatic test_tie_after_reset();
    apply_reset();
    for (int c = 0; c <= 7; c++) begin
      drive_a(c <= 3, 12'h001, c <= 5, 12'h002);
      n_cmp++;
      if ({bus_a.req0_ready, bus_a.req1_ready} !== (c == 0 ? 2'b10 : c == 3 ? 2'b01 : 2'b00)) begin
        n_bad++; $display("FAIL tie_ready c%0d: got %b", c, {bus_a.req0_ready, bus_a.req1_ready});
      end
      n_cmp++; if ({bus_a.rsp0_valid, bus_a.rsp1_valid} !== {c == 3, c == 6}) begin n_bad++; $display("FAIL tie_rsp_valid c%0d: got %b want %b", c, {bus_a.rsp0_valid, bus_a.rsp1_valid}, {c == 3, c == 6}); end
      if (c == 3) begin
        n_cmp++; if (bus_a.rsp0_data !== 8'hA4) begin n_bad++; $display("FAIL tie_data0: got %h want a4", bus_a.rsp0_data); end
      end
      if (c == 6) begin
        n_cmp++; if (bus_a.rsp1_data !== 8'hA7) begin n_bad++; $display("FAIL tie_data1: got %h want a7", bus_a.rsp1_data); end
      end
    end
  endtask

  // Both ports always valid: grants alternate, one accept every three cycles.
  task automatic test_back_to_back();
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] a0, a1;
    int port;
    for (int c = 0; c <= 18; c++) begin
      a0 = AW'($urandom_range(0, 4095));
      a1 = AW'($urandom_range(0, 4095));
      drive_a(c < 18, a0, c < 18, a1);
      port = (c / 3) % 2;
      n_cmp++;
      if ({bus_a.req1_ready, bus_a.req0_ready} !== ((c % 3 == 0 && c < 18) ? 2'(1 << port) : 2'b00)) begin
        n_bad++; $display("FAIL b2b_ready c%0d: got %b", c, {bus_a.req1_ready, bus_a.req0_ready});
      end
      if (c % 3 == 0 && c >= 3) begin
        if (((c / 3) - 1) % 2 == 0) begin
          n_cmp++; if (bus_a.rsp0_valid !== 1'b1 || bus_a.rsp0_data !== exp_q[0]) begin n_bad++; $display("FAIL b2b_rsp0 c%0d: got %b/%h want 1/%h", c, bus_a.rsp0_valid, bus_a.rsp0_data, exp_q[0]); end
        end else begin
          n_cmp++; if (bus_a.rsp1_valid !== 1'b1 || bus_a.rsp1_data !== exp_q[0]) begin n_bad++; $display("FAIL b2b_rsp1 c%0d: got %b/%h want 1/%h", c, bus_a.rsp1_valid, bus_a.rsp1_data, exp_q[0]); end
        end
        void'(exp_q.pop_front());
      end else begin
        n_cmp++; if ({bus_a.rsp0_valid, bus_a.rsp1_valid} !== 2'b00) begin n_bad++; $display("FAIL b2b_rsp_idle c%0d: got %b want 00", c, {bus_a.rsp0_valid, bus_a.rsp1_valid}); end
      end
      if (c % 3 == 0 && c < 18) exp_q.push_back(rom_val(port == 0 ? a0 : a1));
    end
  endtask

  task automatic test_latency2();
    drive_b(1'b0, '0, 1'b1, 12'h0FF);
    n_cmp++; if ({bus_b.req0_ready, bus_b.req1_ready} !== 2'b01) begin n_bad++; $display("FAIL lat2_ready: got %b want 01", {bus_b.req0_ready, bus_b.req1_ready}); end
    for (int c = 1; c <= 5; c++) begin
      drive_b(1'b0, '0, 1'b0, '0);
      n_cmp++; if (busy_b !== (c <= 3)) begin n_bad++; $display("FAIL lat2_busy c%0d: got %b want %b", c, busy_b, c <= 3); end
      n_cmp++; if ({bus_b.rsp0_valid, bus_b.rsp1_valid} !== {1'b0, c == 4}) begin n_bad++; $display("FAIL lat2_rsp_valid c%0d: got %b", c, {bus_b.rsp0_valid, bus_b.rsp1_valid}); end
    end
    n_cmp++; if (bus_b.rsp1_data !== 8'h5A) begin n_bad++; $display("FAIL lat2_data: got %h want 5a", bus_b.rsp1_data); end
    n_cmp++; if (rom_address_b !== 12'h0FF) begin n_bad++; $display("FAIL lat2_rom_addr: got %h want 0ff", rom_address_b); end
  endtask

  task automatic test_reset_mid_wait();
    drive_a(1'b1, 12'h123, 1'b0, '0);
    drive_a(1'b0, '0, 1'b0, '0);
    n_cmp++; if (fsm_state_a !== WAIT) begin n_bad++; $display("FAIL rst_mid_in_wait: got %0d want WAIT", fsm_state_a); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({busy_a, bus_a.rsp0_valid} !== 2'b00) begin n_bad++; $display("FAIL rst_mid_clear: got busy/rsp0 %b want 00", {busy_a, bus_a.rsp0_valid}); end
    n_cmp++; if (rom_address_a !== '0) begin n_bad++; $display("FAIL rst_mid_addr: got %h want 000", rom_address_a); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive_a(1'b0, '0, 1'b0, '0);
      n_cmp++; if ({bus_a.rsp0_valid, bus_a.rsp1_valid, busy_a} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_quiet c%0d: got %b want 000", c, {bus_a.rsp0_valid, bus_a.rsp1_valid, busy_a}); end
    end
    drive_a(1'b1, 12'h004, 1'b1, 12'h005);
    n_cmp++; if ({bus_a.req0_ready, bus_a.req1_ready} !== 2'b10) begin n_bad++; $display("FAIL rst_mid_tie: got %b want 10", {bus_a.req0_ready, bus_a.req1_ready}); end
    for (int c = 0; c < 3; c++) drive_a(1'b0, '0, 1'b0, '0);
    n_cmp++; if (bus_a.rsp0_valid !== 1'b1 || bus_a.rsp0_data !== rom_val(12'h004)) begin n_bad++; $display("FAIL rst_mid_rsp0: got %b/%h want 1/%h", bus_a.rsp0_valid, bus_a.rsp0_data, rom_val(12'h004)); end
  endtask

  task automatic test_drop_valid();
    drive_a(1'b0, '0, 1'b1, 12'h0C3);
    n_cmp++; if (bus_a.req1_ready !== 1'b1) begin n_bad++; $display("FAIL drop_accept1: got %b want 1", bus_a.req1_ready); end
    drive_a(1'b1, 12'h0AA, 1'b0, '0);
    n_cmp++; if (bus_a.req0_ready !== 1'b0) begin n_bad++; $display("FAIL drop_ready0_busy: got %b want 0", bus_a.req0_ready); end
    for (int c = 2; c <= 6; c++) begin
      drive_a(1'b0, '0, 1'b0, '0);
      n_cmp++; if ({bus_a.rsp0_valid, bus_a.rsp1_valid} !== {1'b0, c == 3}) begin n_bad++; $display("FAIL drop_rsp c%0d: got %b", c, {bus_a.rsp0_valid, bus_a.rsp1_valid}); end
      n_cmp++; if (busy_a !== (c < 3)) begin n_bad++; $display("FAIL drop_busy c%0d: got %b want %b", c, busy_a, c < 3); end
    end
    n_cmp++; if (bus_a.rsp1_data !== rom_val(12'h0C3)) begin n_bad++; $display("FAIL drop_data1: got %h want %h", bus_a.rsp1_data, rom_val(12'h0C3)); end
  endtask

  // Timeline reference: a read accepted in cycle k answers in cycle k+3 and
  // frees the ROM in that same cycle; ties go to the port not served last.
  task automatic test_random();
    int            due_q[$];
    logic [DW:0]   exp_q[$];
    int            free_at = 0;
    logic          last_g = 1'b1;
    logic          v0, v1, idle, er0, er1;
    logic [AW-1:0] a0, a1;
    logic [1:0]    exp_rsp;
    apply_reset();
    for (int k = 0; k < 300; k++) begin
      v0 = ($urandom_range(0, 99) < 55);
      v1 = ($urandom_range(0, 99) < 55);
      a0 = AW'($urandom);
      a1 = AW'($urandom);
      drive_a(v0, a0, v1, a1);
      idle = (k >= free_at);
      er0  = idle && v0 && (!v1 || last_g == 1'b1);
      er1  = idle && v1 && (!v0 || last_g == 1'b0);
      n_cmp++; if ({bus_a.req0_ready, bus_a.req1_ready} !== {er0, er1}) begin n_bad++; $display("FAIL rand_ready k%0d: got %b want %b", k, {bus_a.req0_ready, bus_a.req1_ready}, {er0, er1}); end
      n_cmp++; if (busy_a !== !idle) begin n_bad++; $display("FAIL rand_busy k%0d: got %b want %b", k, busy_a, !idle); end
      exp_rsp = 2'b00;
      if (due_q.size() > 0 && due_q[0] == k) begin
        exp_rsp = exp_q[0][DW] ? 2'b01 : 2'b10;
        n_cmp++;
        if ((exp_q[0][DW] ? bus_a.rsp1_data : bus_a.rsp0_data) !== exp_q[0][DW-1:0]) begin
          n_bad++; $display("FAIL rand_data k%0d port%0d: got %h want %h", k, exp_q[0][DW], exp_q[0][DW] ? bus_a.rsp1_data : bus_a.rsp0_data, exp_q[0][DW-1:0]);
        end
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end
      n_cmp++; if ({bus_a.rsp0_valid, bus_a.rsp1_valid} !== exp_rsp) begin n_bad++; $display("FAIL rand_rsp_valid k%0d: got %b want %b", k, {bus_a.rsp0_valid, bus_a.rsp1_valid}, exp_rsp); end
      if (er0 || er1) begin
        last_g  = er1;
        free_at = k + 3;
        due_q.push_back(k + 3);
        exp_q.push_back({er1, rom_val(er1 ? a1 : a0)});
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus_a.req0_valid = 1'b0; bus_a.req0_addr = '0;
    bus_a.req1_valid = 1'b0; bus_a.req1_addr = '0;
    bus_b.req0_valid = 1'b0; bus_b.req0_addr = '0;
    bus_b.req1_valid = 1'b0; bus_b.req1_addr = '0;
    test_reset();
    test_single_port0();
    test_tie_after_reset();
    test_back_to_back();
    test_latency2();
    test_reset_mid_wait();
    test_drop_valid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
